write_back_stage: RTL and testbench
===================================

// Module: write_back_stage
// PURPOSE
//  LEGv8 writeback stage driving the register-file write port (regWrite/writeRegister/writeData).
//  Selects ALU or memory result per memToReg and queues retiring writes in a DEPTH-entry FIFO.
//  Presents one write at a time, holding it until the register file signals regFileReady.
//  Drops writes to X31 (XZR) and never drives Z on writeData.
// PARAMETERS
//  DEPTH      4   FIFO entries; power of 2, >= 2
//  PTR_W      2   log2(DEPTH); count width is PTR_W+1
// PORTS
//  clock          in   1   main clock, all logic on posedge
//  resetN         in   1   synchronous active-low reset
//  wbValid        in   1   retiring instruction present this cycle
//  wbReady        out  1   stage can accept (=!full)
//  regWriteIn     in   1   instruction writes a register
//  memToReg       in   1   1: memData, 0: aluResult
//  destReg        in   5   destination register
//  aluResult      in   32  ALU result
//  memData        in   32  data-memory read data
//  regFileReady   in   1   register file accepts the presented write this cycle
//  regWrite       out  1   write valid to register file
//  writeRegister  out  5   write address
//  writeData      out  32  write data
//  wbPending      out  PTR_W+1  entries queued, including the presented one
//  lookupReg      in   5   bypass query address (WB_BYPASS_EN only; ignored otherwise)
//  bypassHit      out  1   pending write matches lookupReg
//  bypassData     out  32  data of youngest matching entry
// BEHAVIOUR
//  Reset (resetN=0 at posedge): FIFO emptied, wbPending=0, regWrite=0, writeRegister=0,
//   writeData=0, bypassHit=0, bypassData=0, state=IDLE. Takes priority over all inputs, mid-write too.
//  Accept: wbValid&&wbReady. Entry enqueued only if regWriteIn=1 and destReg!=31;
//   else the transfer completes with no enqueue and no other effect.
//  Data mux: memToReg ? memData : aluResult, sampled at the accept edge.
//  wbReady = (wbPending != DEPTH), combinational from the count only (not from the same-cycle pop).
//  FSM: IDLE -- regWrite=0; moves to PRESENT on the edge after the first enqueue.
//   PRESENT -- regWrite=1, writeRegister/writeData = FIFO head, stable until popped.
//   Pop at posedge when regWrite&&regFileReady. Stay in PRESENT if entries remain,
//   next head shown the following cycle. Else go to IDLE (regWrite=0 next cycle).
//  Latency: accept at edge N into an empty stage gives regWrite=1 from edge N+1.
//   Back-to-back entries with regFileReady held high retire one per cycle.
//  Simultaneous enqueue+pop: both take effect and the count is unchanged. At count==DEPTH no
//   enqueue is possible that cycle, since wbReady=0.
//  Ordering: strict FIFO. Two writes to the same register retire oldest first.
//  Pointers wrap modulo DEPTH. Count saturates by construction; overflow/underflow is not reachable.
//  In IDLE, writeRegister/writeData hold the last written values and regWrite=0.
// CONFIGURATION
//  WB_BYPASS_EN defined: combinational search of all valid entries, including the presented head.
//   bypassHit=1 and bypassData=youngest match when lookupReg!=31 and a valid entry has destReg==lookupReg.
//   A same-cycle incoming write is not visible.
//  WB_BYPASS_EN undefined: no search logic; bypassHit=0 and bypassData=0 constantly.
// TESTING
//  Reset, then wbValid=1,regWriteIn=1,memToReg=0,destReg=3,aluResult=32'h1234, regFileReady=1
//   -> next cycle regWrite=1,writeRegister=3,writeData=32'h1234; following cycle regWrite=0.
//  memToReg=1,memData=32'hDEAD_BEEF,aluResult=32'h5,destReg=7 -> writeData=32'hDEAD_BEEF.
//  destReg=31 or regWriteIn=0 with wbValid=1 -> wbPending stays 0 and regWrite stays 0.
//  regFileReady=0, push 4 writes (r1..r4) -> wbPending=4, wbReady=0. Raise regFileReady
//   -> r1..r4 retire on 4 consecutive cycles in order.
//  Full FIFO plus pop in the same cycle: wbReady=0 and no enqueue. Next cycle wbPending=3, wbReady=1.
//  resetN=0 while PRESENT with 3 pending -> next cycle regWrite=0, wbPending=0, writeData=0.
//  WB_BYPASS_EN: queue r5=1 then r5=2, lookupReg=5 -> bypassHit=1, bypassData=2.
//   lookupReg=31 -> bypassHit=0.

Source files
------------

// File: rtl/write_back_stage.sv
// Writeback stage: muxes ALU/memory results into a small FIFO and drains it to the register file.
// Optional combinational bypass search over queued writes is enabled by defining WB_BYPASS_EN.
module write_back_stage #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             wbValid,
  output logic             wbReady,
  input  logic             regWriteIn,
  input  logic             memToReg,
  input  logic [4:0]       destReg,
  input  logic [31:0]      aluResult,
  input  logic [31:0]      memData,
  input  logic             regFileReady,
  output logic             regWrite,
  output logic [4:0]       writeRegister,
  output logic [31:0]      writeData,
  output logic [PTR_W:0]   wbPending,
  input  logic [4:0]       lookupReg,
  output logic             bypassHit,
  output logic [31:0]      bypassData
);

  localparam int            DATA_W = 32;
  localparam logic [4:0]    XZR    = 5'd31;
  localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t state, state_next;

  logic [4:0]        mem_reg  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;
  logic [4:0]        last_reg;
  logic [DATA_W-1:0] last_data;

  logic              accept, enq, pop;
  logic [DATA_W-1:0] in_data;

  assign wbReady   = (count != FULL);
  assign wbPending = count;
  assign accept    = wbValid && wbReady;
  // Writes to XZR and non-writing instructions complete the handshake without queuing.
  assign enq       = accept && regWriteIn && (destReg != XZR);
  assign pop       = regWrite && regFileReady;
  assign in_data   = memToReg ? memData : aluResult;

  // Queue storage holds data only; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem_reg[wr_ptr]  <= destReg;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      last_reg  <= '0;
      last_data <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_reg  <= mem_reg[rd_ptr];
        last_data <= mem_data[rd_ptr];
      end
      count <= count + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enq) state_next = PRESENT;
      PRESENT: if (pop && !enq && (count == (PTR_W + 1)'(1))) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // While idle the port keeps showing the most recently retired write.
  always_comb begin
    regWrite      = 1'b0;
    writeRegister = last_reg;
    writeData     = last_data;
    if (state == PRESENT) begin
      regWrite      = 1'b1;
      writeRegister = mem_reg[rd_ptr];
      writeData     = mem_data[rd_ptr];
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    bypassHit  = 1'b0;
    bypassData = '0;
    if (lookupReg != XZR) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (((PTR_W + 1)'(k) < count) && (mem_reg[rd_ptr + PTR_W'(k)] == lookupReg)) begin
          bypassHit  = 1'b1;
          bypassData = mem_data[rd_ptr + PTR_W'(k)];
        end
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^lookupReg;
  assign bypassHit     = 1'b0;
  assign bypassData    = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage with a queue scoreboard of expected register-file writes.
module tb_write_back_stage;

  logic        clock = 1'b0;
  logic        resetN, wbValid, wbReady, regWriteIn, memToReg;
  logic [4:0]  destReg, writeRegister, lookupReg;
  logic [31:0] aluResult, memData, writeData, bypassData;
  logic        regFileReady, regWrite, bypassHit;
  logic [2:0]  wbPending;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  write_back_stage #(.DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .resetN(resetN), .wbValid(wbValid), .wbReady(wbReady),
    .regWriteIn(regWriteIn), .memToReg(memToReg), .destReg(destReg),
    .aluResult(aluResult), .memData(memData), .regFileReady(regFileReady),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .wbPending(wbPending), .lookupReg(lookupReg), .bypassHit(bypassHit),
    .bypassData(bypassData)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Called just after a falling edge with inputs driven; checks outputs, updates the model, advances one cycle.
  task automatic tick();
    logic        exp_hit;
    logic [31:0] exp_bd;
    bit          enq, pop;
    ent_t        e;
    #1;
    if (resetN) begin
      check("wbPending", 32'(wbPending), 32'(sb.size()));
      check("wbReady", 32'(wbReady), 32'(sb.size() != 4));
      check("regWrite", 32'(regWrite), 32'(sb.size() != 0));
      if (regWrite && sb.size() != 0) begin
        check("writeRegister", 32'(writeRegister), 32'(sb[0].r));
        check("writeData", writeData, sb[0].d);
      end
      exp_hit = 1'b0;
      exp_bd  = '0;
`ifdef WB_BYPASS_EN
      if (lookupReg != 5'd31) begin
        foreach (sb[i]) begin
          if (sb[i].r == lookupReg) begin
            exp_hit = 1'b1;
            exp_bd  = sb[i].d;
          end
        end
      end
`endif
      check("bypassHit", 32'(bypassHit), 32'(exp_hit));
      check("bypassData", bypassData, exp_bd);
      enq = wbValid && (sb.size() != 4) && regWriteIn && (destReg != 5'd31);
      pop = (sb.size() != 0) && regFileReady;
      if (pop) void'(sb.pop_front());
      if (enq) begin
        e.r = destReg;
        e.d = memToReg ? memData : aluResult;
        sb.push_back(e);
      end
    end else begin
      sb.delete();
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    wbValid    = 1'b1;
    regWriteIn = 1'b1;
    memToReg   = 1'b0;
    destReg    = r;
    aluResult  = d;
    tick();
  endtask

  initial begin
    resetN = 1'b0; wbValid = 1'b0; regWriteIn = 1'b0; memToReg = 1'b0;
    destReg = '0; aluResult = '0; memData = '0; regFileReady = 1'b0; lookupReg = '0;
    @(negedge clock);
    tick();
    tick();
    resetN = 1'b1;
    #1;
    check("rst_regWrite", 32'(regWrite), 32'd0);
    check("rst_wbPending", 32'(wbPending), 32'd0);
    check("rst_writeRegister", 32'(writeRegister), 32'd0);
    check("rst_writeData", writeData, 32'd0);
    check("rst_bypassHit", 32'(bypassHit), 32'd0);
    check("rst_bypassData", bypassData, 32'd0);

    // Single ALU write, then idle hold of the last written values
    regFileReady = 1'b1;
    wr(5'd3, 32'h1234);
    wbValid = 1'b0;
    tick();
    tick();
    check("idle_writeRegister", 32'(writeRegister), 32'd3);
    check("idle_writeData", writeData, 32'h1234);

    // Memory-sourced write
    wbValid = 1'b1; regWriteIn = 1'b1; memToReg = 1'b1;
    destReg = 5'd7; memData = 32'hDEAD_BEEF; aluResult = 32'h5;
    tick();
    wbValid = 1'b0;
    tick();
    tick();
    check("mem_idle_writeData", writeData, 32'hDEAD_BEEF);

    // Dropped writes: XZR destination and regWriteIn=0
    wbValid = 1'b1; regWriteIn = 1'b1; memToReg = 1'b0; destReg = 5'd31; aluResult = 32'h99;
    tick();
    regWriteIn = 1'b0; destReg = 5'd4;
    tick();
    wbValid = 1'b0;
    tick();

    // Fill with the register file stalled, then a full-plus-pop cycle
    regFileReady = 1'b0;
    for (int i = 1; i <= 4; i++) wr(5'(i), 32'h100 + 32'(i));
    wbValid = 1'b0;
    tick();
    check("full_wbReady", 32'(wbReady), 32'd0);
    wr(5'd9, 32'h999);
    regFileReady = 1'b1;
    wr(5'd9, 32'h999);
    wbValid = 1'b0;
    check("after_full_pending", 32'(wbPending), 32'd3);
    for (int i = 0; i < 4; i++) tick();

    // Reset while presenting with three writes pending
    regFileReady = 1'b0;
    for (int i = 0; i < 3; i++) wr(5'(10 + i), 32'hA0 + 32'(i));
    wbValid = 1'b0;
    tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    #1;
    check("midrst_regWrite", 32'(regWrite), 32'd0);
    check("midrst_wbPending", 32'(wbPending), 32'd0);
    check("midrst_writeData", writeData, 32'd0);
    @(negedge clock);

    // Same-register ordering and bypass lookup
    lookupReg = 5'd5;
    wr(5'd5, 32'd1);
    wr(5'd5, 32'd2);
    wr(5'd6, 32'd3);
    wbValid = 1'b0;
    tick();
`ifdef WB_BYPASS_EN
    check("byp_hit_r5", 32'(bypassHit), 32'd1);
    check("byp_data_r5", bypassData, 32'd2);
`endif
    lookupReg = 5'd31;
    #1;
    check("byp_hit_xzr", 32'(bypassHit), 32'd0);
    @(negedge clock);
    lookupReg = 5'd6;
    tick();
    regFileReady = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
